// File: rtl/ram8_16.sv
// ram8_16: eight 16-bit registers with a combinational mux8way16 read path
// and a hardware bulk-clear sweep.
//
// Request/status protocol: clear is a one-cycle request. It is taken on a
// rising clk edge only while busy=0, and busy goes high on the next cycle.
// While busy=1 both load and clear are dropped, not queued. A caller that
// wants its write to land must wait until it sees busy=0.

// 8-way 16-bit multiplexer: out = the input picked by sel (a when sel=0, h when sel=7).
module mux8way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);

  // Pure combinational select, no storage.
  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end

endmodule

module ram8_16 #(
  // The read mux is fixed at 16 bits, so 16 is the only working width.
  parameter int unsigned             WIDTH       = 16,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             dbg_state
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] words_q [8];

  // A single write port is shared by normal writes and by the sweep.
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  // Next-state logic and selection of the write port source.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = in;
    if (state_q == IDLE) begin
      // A load taken on the same edge as clear still happens. The sweep
      // overwrites it later.
      wr_en = load;
      if (clear) begin
        state_d = SWEEP;
        cnt_d   = 3'd0;
      end
    end else begin
      // During the sweep, load and clear are ignored. One word is cleared per edge.
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = CLEAR_VALUE;
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        state_d = IDLE;
      end
    end
  end

  // FSM state and sweep counter. Reset returns to IDLE, and the sweep does not resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word storage. Reset loads every word at once, with no clock needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        words_q[i] <= CLEAR_VALUE;
      end
    end else if (wr_en) begin
      words_q[wr_addr] <= wr_data;
    end
  end

  // The read path is not registered. out follows an address change in the same cycle.
  mux8way16 u_mux (
    .a   (words_q[0]),
    .b   (words_q[1]),
    .c   (words_q[2]),
    .d   (words_q[3]),
    .e   (words_q[4]),
    .f   (words_q[5]),
    .g   (words_q[6]),
    .h   (words_q[7]),
    .sel (address),
    .out (out)
  );

  assign busy      = (state_q == SWEEP);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram8_16.sv
// Directed bench for ram8_16: reset, write/read, read-old, clear sweep,
// hazards during the sweep, and reset in the middle of a sweep.
module tb_ram8_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;
  logic        dbg_state;

  int checks;
  int failures;

  ram8_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .load      (load),
    .address   (address),
    .clear     (clear),
    .out       (out),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one write cycle, returning 1 ns after the edge with load low.
  task automatic drive_write(input logic [2:0] a, input logic [15:0] d);
    load    = 1'b1;
    address = a;
    in      = d;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Driver: a one-cycle clear pulse. Returns 1 ns after the edge that takes it.
  task automatic drive_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // Driver: wait n clock edges and return 1 ns after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #0.5;
      checks++;
      if (out !== 16'h0000) begin
        failures++;
        $display("FAIL reset_word%0d got=%h exp=0000", k, out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_write_read_all();
    logic [15:0] exp;
    for (int k = 0; k < 8; k++) begin
      drive_write(3'(k), 16'h1111 * 16'(k + 1));
    end
    for (int k = 0; k < 8; k++) begin
      exp = 16'h1111 * 16'(k + 1);
      address = 3'(k);
      #1;
      checks++;
      if (out !== exp) begin
        failures++;
        $display("FAIL wr_all_word%0d got=%h exp=%h", k, out, exp);
      end
    end
  endtask

  task automatic test_read_old();
    drive_write(3'd3, 16'hBEEF);
    load    = 1'b1;
    address = 3'd3;
    in      = 16'h1234;
    #1;
    checks++;
    if (out !== 16'hBEEF) begin
      failures++;
      $display("FAIL read_old_same_cycle got=%h exp=beef", out);
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    checks++;
    if (out !== 16'h1234) begin
      failures++;
      $display("FAIL read_old_next_cycle got=%h exp=1234", out);
    end
    address = 3'd2;
    #1;
    checks++;
    if (out !== 16'h3333) begin
      failures++;
      $display("FAIL read_old_neighbor2 got=%h exp=3333", out);
    end
    address = 3'd4;
    #1;
    checks++;
    if (out !== 16'h5555) begin
      failures++;
      $display("FAIL read_old_neighbor4 got=%h exp=5555", out);
    end
  endtask

  task automatic test_clear_sweep();
    int busy_cycles;
    logic [15:0] exp;
    address = 3'd5;
    busy_cycles = 0;
    drive_clear();
    // Edges 1..8 after the clear edge clear words 0..7 in order.
    for (int i = 1; i <= 8; i++) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk);
      #1;
      exp = (i >= 6) ? 16'h0000 : 16'h6666;
      checks++;
      if (out !== exp) begin
        failures++;
        $display("FAIL sweep_addr5_edge%0d got=%h exp=%h", i, out, exp);
      end
    end
    checks++;
    if (busy_cycles != 8 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_busy_len got=%0d busy_now=%b exp=8 busy_now=0", busy_cycles, busy);
    end
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #1;
      checks++;
      if (out !== 16'h0000) begin
        failures++;
        $display("FAIL sweep_after_word%0d got=%h exp=0000", k, out);
      end
    end
  endtask

  task automatic test_hazards_during_sweep();
    int busy_cycles;
    for (int k = 0; k < 8; k++) begin
      drive_write(3'(k), 16'h1111 * 16'(k + 1));
    end
    busy_cycles = 0;
    drive_clear();
    for (int i = 1; i <= 8; i++) begin
      if (busy === 1'b1) busy_cycles++;
      if (i == 3) begin
        load    = 1'b1;
        address = 3'd7;
        in      = 16'hAAAA;
        clear   = 1'b1;
      end
      @(posedge clk);
      #1;
      load  = 1'b0;
      clear = 1'b0;
    end
    checks++;
    if (busy_cycles != 8 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hazard_busy_len got=%0d busy_now=%b exp=8 busy_now=0", busy_cycles, busy);
    end
    address = 3'd7;
    #1;
    checks++;
    if (out !== 16'h0000) begin
      failures++;
      $display("FAIL hazard_word7 got=%h exp=0000", out);
    end
    drive_write(3'd7, 16'h5A5A);
    checks++;
    if (out !== 16'h5A5A || busy !== 1'b0) begin
      failures++;
      $display("FAIL hazard_write_after got=%h busy=%b exp=5a5a busy=0", out, busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int k = 0; k < 8; k++) begin
      drive_write(3'(k), 16'hFFFF);
    end
    drive_clear();
    step(4);
    #1;
    rst_n = 1'b0;
    #0.5;
    checks++;
    if (busy !== 1'b0 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL midreset_busy got=%b state=%b exp=0 state=0", busy, dbg_state);
    end
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #0.5;
      checks++;
      if (out !== 16'h0000) begin
        failures++;
        $display("FAIL midreset_word%0d got=%h exp=0000", k, out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    drive_write(3'd6, 16'h0F0F);
    address = 3'd6;
    #1;
    checks++;
    if (out !== 16'h0F0F) begin
      failures++;
      $display("FAIL midreset_write6 got=%h exp=0f0f", out);
    end
    step(3);
    checks++;
    if (busy !== 1'b0 || out !== 16'h0F0F) begin
      failures++;
      $display("FAIL midreset_no_resume busy=%b out=%h exp busy=0 out=0f0f", busy, out);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    in       = 16'h0000;
    load     = 1'b0;
    address  = 3'd0;
    clear    = 1'b0;
    test_reset();
    test_write_read_all();
    test_read_old();
    test_clear_sweep();
    test_hazards_during_sweep();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
